// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Fetch sequencer for a simple 16-bit pipelined core. It owns the program
//   counter, issues one instruction-memory request at a time, and buffers the
//   returned instruction for the IF/ID stage. It also handles taken-branch
//   redirects and the HLT instruction.
//
//   Memory transactions are never abandoned (reset excepted). If a redirect
//   or HLT arrives while a request is still outstanding, the sequencer moves
//   to DRAIN. In DRAIN it keeps the request asserted and waits for the
//   acknowledge, then throws the returned data away.
//
// Ports:
//   clk          in   1   single clock, all state updates on the rising edge
//   rst          in   1   asynchronous, active-high reset
//   stall        in   1   IF/ID cannot accept the presented instruction
//   br_valid     in   1   branch resolution valid this cycle
//   br_taken     in   1   resolved branch is taken
//   br_target    in  16   redirect address (bit 0 is forced to zero)
//   hlt          in   1   HLT decoded, stop fetching
//   imem_ack     in   1   instruction memory returns data this cycle
//   imem_data    in  16   instruction word, valid with imem_ack
//   imem_req     out  1   fetch request
//   imem_addr    out 16   fetch address
//   instr_valid  out  1   instr_out / instr_pc hold a valid instruction
//   instr_out    out 16   buffered instruction
//   instr_pc     out 16   address of instr_out
//   flush        out  1   squash younger pipeline state (br_valid & br_taken)
//   halted       out  1   fetch stopped by HLT
// ---------------------------------------------------------------------------
module pc_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        hlt,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic        instr_valid,
    output logic [15:0] instr_out,
    output logic [15:0] instr_pc,
    output logic        flush,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] pc;
    logic [15:0] pc_next;
    logic [15:0] instr_out_next;
    logic [15:0] instr_pc_next;
    logic        halt_pend;
    logic        halt_pend_next;

    // Address of the transaction being drained. A redirect during DRAIN
    // moves pc to the new target while the old request is still
    // outstanding. This register keeps imem_addr stable until that request
    // is acknowledged.
    logic [15:0] drain_addr;
    logic [15:0] drain_addr_next;

    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pc_plus2;

    // A redirect is only a taken, resolved branch. Instructions are
    // halfword aligned, so bit 0 of the target is dropped.
    assign redirect    = br_valid & br_taken;
    assign redirect_pc = {br_target[15:1], 1'b0};
    // Natural 16-bit overflow wraps 16'hFFFE to 16'h0000.
    assign pc_plus2    = pc + 16'd2;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= 16'h0000;
            instr_out  <= 16'h0000;
            instr_pc   <= 16'h0000;
            halt_pend  <= 1'b0;
            drain_addr <= 16'h0000;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            instr_out  <= instr_out_next;
            instr_pc   <= instr_pc_next;
            halt_pend  <= halt_pend_next;
            drain_addr <= drain_addr_next;
        end
    end

    // Next-state and next-register logic. Every register holds by default.
    // A redirect always takes priority over hlt and cancels any pending halt.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        instr_out_next  = instr_out;
        instr_pc_next   = instr_pc;
        halt_pend_next  = halt_pend;
        drain_addr_next = drain_addr;

        case (state)
            FETCH: begin
                if (redirect) begin
                    pc_next        = redirect_pc;
                    halt_pend_next = 1'b0;
                    // With ack, the returned word is simply not captured.
                    // Without ack, the request must still be drained.
                    if (!imem_ack) begin
                        state_next      = DRAIN;
                        drain_addr_next = pc;
                    end
                end else if (hlt) begin
                    if (imem_ack) begin
                        state_next = HALT;
                    end else begin
                        halt_pend_next  = 1'b1;
                        state_next      = DRAIN;
                        drain_addr_next = pc;
                    end
                end else if (imem_ack) begin
                    instr_out_next = imem_data;
                    instr_pc_next  = pc;
                    pc_next        = pc_plus2;
                    state_next     = VALID;
                end
            end

            VALID: begin
                if (redirect) begin
                    pc_next        = redirect_pc;
                    halt_pend_next = 1'b0;
                    state_next     = FETCH;
                end else if (hlt) begin
                    state_next = HALT;
                end else if (!stall) begin
                    state_next = FETCH;
                end
            end

            DRAIN: begin
                if (redirect) begin
                    pc_next        = redirect_pc;
                    halt_pend_next = 1'b0;
                end else if (hlt) begin
                    halt_pend_next = 1'b1;
                end
                // The exit decision uses the updated pending flag.
                // A redirect or hlt in the acknowledge cycle then counts.
                if (imem_ack) begin
                    state_next = halt_pend_next ? HALT : FETCH;
                end
            end

            HALT: begin
                // Only reset leaves HALT.
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Registered-state outputs. The flush output is a pure function of the
    // branch inputs.
    always_comb begin
        imem_req    = (state == FETCH) || (state == DRAIN);
        imem_addr   = (state == DRAIN) ? drain_addr : pc;
        instr_valid = (state == VALID);
        halted      = (state == HALT);
        flush       = redirect;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Purpose:
//   Self-checking bench for pc_sequencer. It applies a table of one-cycle
//   vectors. Each vector holds the inputs for a cycle and the outputs
//   expected in that cycle. The expected record is queued when the inputs
//   are driven, then popped and compared mid-cycle. Hand-written sequences
//   after the table cover an asynchronous reset that lands mid-transaction.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic        hlt = 1'b0;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        flush;
    logic        halted;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br_valid;
        logic        br_taken;
        logic [15:0] br_target;
        logic        hlt;
        logic        imem_ack;
        logic [15:0] imem_data;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_out;
        logic [15:0] exp_pc;
        logic        exp_flush;
        logic        exp_halted;
    } vec_t;

    vec_t vectors[$];
    vec_t expq[$];

    pc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .hlt        (hlt),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .instr_valid(instr_valid),
        .instr_out  (instr_out),
        .instr_pc   (instr_pc),
        .flush      (flush),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Stop a runaway simulation with a visible failure.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(
        input logic r, input logic s, input logic bv, input logic bt,
        input logic [15:0] tgt, input logic h, input logic a,
        input logic [15:0] d,
        input logic q, input logic [15:0] ad, input logic vl,
        input logic [15:0] io, input logic [15:0] ip,
        input logic fl, input logic hl);
        vec_t v;
        v.rst = r;       v.stall = s;     v.br_valid = bv;  v.br_taken = bt;
        v.br_target = tgt; v.hlt = h;     v.imem_ack = a;   v.imem_data = d;
        v.exp_req = q;   v.exp_addr = ad; v.exp_valid = vl;
        v.exp_out = io;  v.exp_pc = ip;   v.exp_flush = fl; v.exp_halted = hl;
        vectors.push_back(v);
    endfunction

    task automatic checkWord(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %b required %b", name, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        stall     = v.stall;
        br_valid  = v.br_valid;
        br_taken  = v.br_taken;
        br_target = v.br_target;
        hlt       = v.hlt;
        imem_ack  = v.imem_ack;
        imem_data = v.imem_data;
        expq.push_back(v);
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        if (expq.size() == 0) begin
            checks++;
            $display("[TB] FAIL v%0d scoreboard: got empty queue required entry", idx);
        end else begin
            e = expq.pop_front();
            checkBit ($sformatf("v%0d imem_req", idx),    imem_req,    e.exp_req);
            checkWord($sformatf("v%0d imem_addr", idx),   imem_addr,   e.exp_addr);
            checkBit ($sformatf("v%0d instr_valid", idx), instr_valid, e.exp_valid);
            checkWord($sformatf("v%0d instr_out", idx),   instr_out,   e.exp_out);
            checkWord($sformatf("v%0d instr_pc", idx),    instr_pc,    e.exp_pc);
            checkBit ($sformatf("v%0d flush", idx),       flush,       e.exp_flush);
            checkBit ($sformatf("v%0d halted", idx),      halted,      e.exp_halted);
        end
    endtask

    initial begin
        //       rst stl bv bt target    hlt ack data      req addr     vld out       pc        fl hl
        // Reset, then a free-running fetch with ack tied high.
        addVec(Y, N, N, N, 16'h0000, N, N, 16'h0000, Y, 16'h0000, N, 16'h0000, 16'h0000, N, N);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'hA000, Y, 16'h0000, N, 16'h0000, 16'h0000, N, N);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'hFFFF, N, 16'h0002, Y, 16'hA000, 16'h0000, N, N);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'hA002, Y, 16'h0002, N, 16'hA000, 16'h0000, N, N);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'hFFFF, N, 16'h0004, Y, 16'hA002, 16'h0002, N, N);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'hA004, Y, 16'h0004, N, 16'hA002, 16'h0002, N, N);
        // Stall in VALID for three cycles, then release.
        addVec(N, Y, N, N, 16'h0000, N, N, 16'h0000, N, 16'h0006, Y, 16'hA004, 16'h0004, N, N);
        addVec(N, Y, N, N, 16'h0000, N, Y, 16'hEEEE, N, 16'h0006, Y, 16'hA004, 16'h0004, N, N);
        addVec(N, Y, N, N, 16'h0000, N, N, 16'h0000, N, 16'h0006, Y, 16'hA004, 16'h0004, N, N);
        addVec(N, N, N, N, 16'h0000, N, N, 16'h0000, N, 16'h0006, Y, 16'hA004, 16'h0004, N, N);
        addVec(N, N, N, N, 16'h0000, N, N, 16'h0000, Y, 16'h0006, N, 16'hA004, 16'h0004, N, N);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'hA006, Y, 16'h0006, N, 16'hA004, 16'h0004, N, N);
        // A not-taken branch has no effect. A taken branch in VALID under stall redirects to 0x0010.
        addVec(N, Y, Y, N, 16'h1234, N, N, 16'h0000, N, 16'h0008, Y, 16'hA006, 16'h0006, N, N);
        addVec(N, Y, Y, Y, 16'h0011, N, N, 16'h0000, N, 16'h0008, Y, 16'hA006, 16'h0006, Y, N);
        // Redirect while the fetch at 0x0010 is outstanding: drain, then fetch 0x0040.
        addVec(N, N, Y, Y, 16'h0041, N, N, 16'h0000, Y, 16'h0010, N, 16'hA006, 16'h0006, Y, N);
        addVec(N, N, N, N, 16'h0000, N, N, 16'h0000, Y, 16'h0010, N, 16'hA006, 16'h0006, N, N);
        addVec(N, N, N, N, 16'h0000, N, N, 16'h0000, Y, 16'h0010, N, 16'hA006, 16'h0006, N, N);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'hBEEF, Y, 16'h0010, N, 16'hA006, 16'h0006, N, N);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'hA040, Y, 16'h0040, N, 16'hA006, 16'h0006, N, N);
        // hlt together with a taken branch: the branch wins.
        addVec(N, N, Y, Y, 16'h0100, Y, N, 16'h0000, N, 16'h0042, Y, 16'hA040, 16'h0040, Y, N);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'hA100, Y, 16'h0100, N, 16'hA040, 16'h0040, N, N);
        addVec(N, N, N, N, 16'h0000, N, N, 16'h0000, N, 16'h0102, Y, 16'hA100, 16'h0100, N, N);
        // Redirect together with ack in FETCH: the data is dropped and fetch restarts at the target.
        addVec(N, N, Y, Y, 16'h0200, N, Y, 16'hDEAD, Y, 16'h0102, N, 16'hA100, 16'h0100, Y, N);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'hA200, Y, 16'h0200, N, 16'hA100, 16'h0100, N, N);
        // hlt in VALID goes straight to HALT, which ignores its inputs.
        addVec(N, N, N, N, 16'h0000, Y, N, 16'h0000, N, 16'h0202, Y, 16'hA200, 16'h0200, N, N);
        addVec(N, Y, N, N, 16'h0000, Y, Y, 16'h3333, N, 16'h0202, N, 16'hA200, 16'h0200, N, Y);
        addVec(N, N, Y, N, 16'h0300, N, Y, 16'h4444, N, 16'h0202, N, 16'hA200, 16'h0200, N, Y);
        // Reset, then hlt in FETCH with ack two cycles later: drain, then halt.
        addVec(Y, N, N, N, 16'h0000, N, N, 16'h0000, Y, 16'h0000, N, 16'h0000, 16'h0000, N, N);
        addVec(N, N, N, N, 16'h0000, Y, N, 16'h0000, Y, 16'h0000, N, 16'h0000, 16'h0000, N, N);
        addVec(N, N, N, N, 16'h0000, N, N, 16'h0000, Y, 16'h0000, N, 16'h0000, 16'h0000, N, N);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'h1234, Y, 16'h0000, N, 16'h0000, 16'h0000, N, N);
        addVec(N, N, N, N, 16'h0000, N, N, 16'h0000, N, 16'h0000, N, 16'h0000, 16'h0000, N, Y);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'h5678, N, 16'h0000, N, 16'h0000, 16'h0000, N, Y);
        // Reset, redirect to 0xFFFF (becomes 0xFFFE), then the PC wraps to 0x0000.
        addVec(Y, N, N, N, 16'h0000, N, N, 16'h0000, Y, 16'h0000, N, 16'h0000, 16'h0000, N, N);
        addVec(N, N, Y, Y, 16'hFFFF, N, Y, 16'h5555, Y, 16'h0000, N, 16'h0000, 16'h0000, Y, N);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'h7777, Y, 16'hFFFE, N, 16'h0000, 16'h0000, N, N);
        addVec(N, N, N, N, 16'h0000, N, N, 16'h0000, N, 16'h0000, Y, 16'h7777, 16'hFFFE, N, N);
        // hlt together with ack in FETCH: the data is dropped and the block halts.
        addVec(N, N, N, N, 16'h0000, Y, Y, 16'h9999, Y, 16'h0000, N, 16'h7777, 16'hFFFE, N, N);
        addVec(N, N, N, N, 16'h0000, N, N, 16'h0000, N, 16'h0000, N, 16'h7777, 16'hFFFE, N, Y);
        // A redirect during DRAIN cancels the pending halt. A later hlt during DRAIN sets it again.
        addVec(Y, N, N, N, 16'h0000, N, N, 16'h0000, Y, 16'h0000, N, 16'h0000, 16'h0000, N, N);
        addVec(N, N, N, N, 16'h0000, Y, N, 16'h0000, Y, 16'h0000, N, 16'h0000, 16'h0000, N, N);
        addVec(N, N, Y, Y, 16'h0080, N, N, 16'h0000, Y, 16'h0000, N, 16'h0000, 16'h0000, Y, N);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'h2222, Y, 16'h0000, N, 16'h0000, 16'h0000, N, N);
        addVec(N, Y, N, N, 16'h0000, N, N, 16'h0000, Y, 16'h0080, N, 16'h0000, 16'h0000, N, N);
        addVec(N, N, Y, N, 16'h1111, N, Y, 16'h8080, Y, 16'h0080, N, 16'h0000, 16'h0000, N, N);
        addVec(N, N, N, N, 16'h0000, N, N, 16'h0000, N, 16'h0082, Y, 16'h8080, 16'h0080, N, N);
        addVec(N, N, Y, Y, 16'h0090, N, N, 16'h0000, Y, 16'h0082, N, 16'h8080, 16'h0080, Y, N);
        addVec(N, N, N, N, 16'h0000, Y, N, 16'h0000, Y, 16'h0082, N, 16'h8080, 16'h0080, N, N);
        addVec(N, N, N, N, 16'h0000, N, Y, 16'h6666, Y, 16'h0082, N, 16'h8080, 16'h0080, N, N);
        addVec(N, N, N, N, 16'h0000, N, N, 16'h0000, N, 16'h0090, N, 16'h8080, 16'h0080, N, Y);

        for (int i = 0; i < vectors.size(); i++) begin
            @(posedge clk);
            #1 applyStimulus(vectors[i]);
            #3 checkOutput(i);
        end

        // Asynchronous reset landing between edges while a DRAIN is pending.
        @(posedge clk);
        #1 rst = 1'b1; stall = 1'b0; hlt = 1'b0; imem_ack = 1'b0;
        br_valid = 1'b0; br_taken = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        br_valid = 1'b1; br_taken = 1'b1; br_target = 16'h0500;
        #3 checkBit("seq redirect flush", flush, 1'b1);
        @(posedge clk);
        #1 br_valid = 1'b0; br_taken = 1'b0;
        #3 checkWord("seq drain addr", imem_addr, 16'h0000);
        #1 rst = 1'b1;
        #1 checkBit("seq async rst req", imem_req, 1'b1);
        checkBit("seq async rst halted", halted, 1'b0);
        #1 rst = 1'b0; imem_ack = 1'b1; imem_data = 16'hC0DE;

        // Bounded wait for the first instruction after reset.
        for (int k = 0; k < 8 && instr_valid !== 1'b1; k++) @(negedge clk);
        checkBit ("seq post-rst instr_valid", instr_valid, 1'b1);
        checkWord("seq post-rst instr_out", instr_out, 16'hC0DE);
        checkWord("seq post-rst instr_pc", instr_pc, 16'h0000);
        imem_ack = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
